// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
//
// RAM-side responder for the cache/RAM bus. It holds a word-addressed memory
// and answers each level-held request after LAT wait cycles (BUSY), followed
// by a single ACCESS cycle. Illegal requests park the FSM in ERROR.
//
// Ports:
//   CLK      - clock, all state changes on the rising edge
//   RST      - synchronous active-high reset
//   ramREN   - read request (level, held until ACCESS is seen)
//   ramWEN   - write request (level, held until ACCESS is seen)
//   ramaddr  - byte address; word index = ramaddr[log2(DEPTH)+1:2]
//   ramstore - write data
//   ramload  - read data, valid during ACCESS of a read, held otherwise
//   ramstate - FREE / BUSY / ACCESS / ERROR, straight from the state register
// ---------------------------------------------------------------------------
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0]  LAT_RELOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  // Everything that identifies a request; the write data only counts when
  // the request is a write.
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t data;
  } key_t;

  ramstate_t      state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  key_t           key_q, key_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  key_t           key_in;
  logic           req;
  logic           illegal;
  logic           fire;
  logic           do_write;
  logic           do_read;
  logic [AW-1:0]  idx;

  // Array storage plus its read register. The array itself is never reset so
  // it maps onto block RAM; "every word reads as zero after reset" is provided
  // by the per-word valid bits instead.
  word_t          mem [DEPTH];
  word_t          rd_word_q;
  logic           rd_valid_q;

  always_comb begin
    req     = ramREN | ramWEN;
    illegal = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
              ({1'b0, ramaddr} >= ADDR_LIMIT);
    key_in  = '{ren: ramREN, wen: ramWEN, addr: ramaddr,
                data: ramWEN ? ramstore : '0};
    idx     = ramaddr[AW+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    fire    = 1'b0;
    case (state_q)
      BUSY: begin
        if (!req) begin
          state_d = FREE;
        end else if (illegal) begin
          state_d = ERROR;
        end else if (key_in != key_q) begin
          // Requester changed its mind: the full latency starts over.
          cnt_d = LAT_RELOAD;
          key_d = key_in;
        end else if (cnt_q == 4'd0) begin
          state_d = ACCESS;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        // FREE, ACCESS and ERROR all treat the current inputs as a new request.
        if (!req) begin
          state_d = FREE;
        end else if (illegal) begin
          state_d = ERROR;
        end else begin
          key_d = key_in;
          if (LAT > 0) begin
            state_d = BUSY;
            cnt_d   = LAT_RELOAD;
          end else begin
            state_d = ACCESS;
            fire    = 1'b1;
          end
        end
      end
    endcase
  end

  // The access happens on the edge entering ACCESS; at that edge the inputs
  // equal the latched key, so they address the array directly.
  always_comb begin
    do_write = fire & ramWEN;
    do_read  = fire & ramREN;
    valid_d  = valid_q;
    if (do_write) begin
      valid_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      key_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  // Reset must also cancel a write that would otherwise land on this edge.
  always_ff @(posedge CLK) begin
    if (do_write && !RST) begin
      mem[idx] <= ramstore;
    end
    if (do_read) begin
      rd_word_q <= mem[idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid_q <= 1'b0;
    end else if (do_read) begin
      rd_valid_q <= valid_q[idx];
    end
  end

  assign ramload  = rd_valid_q ? rd_word_q : '0;
  assign ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_ram_responder
//
// Four responders with LAT = 2, 0, 3, 4 share one clock; each row of the
// vector table drives one of them for one cycle and states the ramstate and
// ramload expected after that edge. Expectations go through a scoreboard
// queue and are compared #1 after the edge.
// ---------------------------------------------------------------------------
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int NDUT = 4;

  logic      clk = 1'b0;
  logic      rst_v   [NDUT];
  logic      ren_v   [NDUT];
  logic      wen_v   [NDUT];
  word_t     addr_v  [NDUT];
  word_t     store_v [NDUT];
  word_t     load_v  [NDUT];
  ramstate_t st_v    [NDUT];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      ram_responder #(
        .LAT  ((gi == 0) ? 2 : (gi == 1) ? 0 : (gi == 2) ? 3 : 4),
        .DEPTH(1024)
      ) u_dut (
        .CLK     (clk),
        .RST     (rst_v[gi]),
        .ramREN  (ren_v[gi]),
        .ramWEN  (wen_v[gi]),
        .ramaddr (addr_v[gi]),
        .ramstore(store_v[gi]),
        .ramload (load_v[gi]),
        .ramstate(st_v[gi])
      );
    end
  endgenerate

  typedef struct {
    int        d;
    bit        rst;
    bit        ren;
    bit        wen;
    word_t     addr;
    word_t     store;
    ramstate_t st;
    word_t     ld;
  } vec_t;

  typedef struct {
    int        d;
    ramstate_t st;
    word_t     ld;
    int        row;
  } exp_t;

  vec_t  vecs  [$];
  string names [$];
  exp_t  sb    [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int d, input bit rst, input bit ren, input bit wen,
                     input word_t addr, input word_t store,
                     input ramstate_t st, input word_t ld, input string nm);
    vec_t v;
    v = '{d: d, rst: rst, ren: ren, wen: wen, addr: addr, store: store, st: st, ld: ld};
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  // A complete request: nbusy BUSY rows, one ACCESS row, then a FREE row once
  // the requester drops the request. ld0 is the load held before, ld1 after.
  task automatic add_req(input int d, input bit ren, input bit wen, input word_t addr,
                         input word_t store, input int nbusy,
                         input word_t ld0, input word_t ld1, input string nm);
    for (int i = 0; i < nbusy; i++) add(d, 0, ren, wen, addr, store, BUSY, ld0, nm);
    add(d, 0, ren, wen, addr, store, ACCESS, ld1, nm);
    add(d, 0, 0, 0, 0, 0, FREE, ld1, {nm, "_idle"});
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      rst_v[k] = 1'b0; ren_v[k] = 1'b0; wen_v[k] = 1'b0;
      addr_v[k] = '0;  store_v[k] = '0;
    end
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   cyc;
    bit   found;

    // ---------------- vector table ----------------
    // DUT0, LAT=2
    add_req(0, 1, 0, 32'h40, 0, 2, 0, 0, "rd40_after_rst");
    add_req(0, 0, 1, 32'h10, 32'hDEADBEEF, 2, 0, 0, "wr10");
    add_req(0, 1, 0, 32'h10, 0, 2, 0, 32'hDEADBEEF, "rd10");
    add(0, 0, 1, 1, 32'h0, 32'h12345678, ERROR, 32'hDEADBEEF, "both_hi");
    add(0, 0, 1, 1, 32'h0, 32'h12345678, ERROR, 32'hDEADBEEF, "both_hold");
    add(0, 0, 0, 0, 0, 0, FREE, 32'hDEADBEEF, "both_drop");
    add(0, 0, 1, 0, 32'h2, 0, ERROR, 32'hDEADBEEF, "misalign");
    add_req(0, 1, 0, 32'h0, 0, 2, 32'hDEADBEEF, 0, "err_to_rd0");
    add(0, 0, 1, 0, 32'h1000, 0, ERROR, 0, "addr_4depth");
    add(0, 0, 1, 0, 32'h1000, 0, ERROR, 0, "addr_4d_hold");
    add(0, 0, 0, 0, 0, 0, FREE, 0, "addr_4d_drop");
    add(0, 0, 0, 1, 32'h80000000, 32'h1, ERROR, 0, "addr_high");
    add(0, 0, 0, 0, 0, 0, FREE, 0, "addr_high_drop");
    add_req(0, 0, 1, 32'hFFC, 32'hCAFEF00D, 2, 0, 0, "wr_last");
    add_req(0, 1, 0, 32'hFFC, 0, 2, 0, 32'hCAFEF00D, "rd_last");
    // DUT1, LAT=0: streaming writes then reads, one ACCESS per cycle
    add(1, 0, 0, 1, 32'h0, 32'h11111111, ACCESS, 0, "stream_w0");
    add(1, 0, 0, 1, 32'h4, 32'h22222222, ACCESS, 0, "stream_w4");
    add(1, 0, 0, 1, 32'h8, 32'h33333333, ACCESS, 0, "stream_w8");
    add(1, 0, 0, 0, 0, 0, FREE, 0, "stream_widle");
    add(1, 0, 1, 0, 32'h0, 0, ACCESS, 32'h11111111, "stream_r0");
    add(1, 0, 1, 0, 32'h4, 0, ACCESS, 32'h22222222, "stream_r4");
    add(1, 0, 1, 0, 32'h8, 0, ACCESS, 32'h33333333, "stream_r8");
    add(1, 0, 0, 0, 0, 0, FREE, 32'h33333333, "stream_ridle");
    add(1, 0, 0, 1, 32'hC, 32'h44444444, ACCESS, 32'h33333333, "b2b_wr");
    add(1, 0, 1, 0, 32'hC, 0, ACCESS, 32'h44444444, "b2b_rd");
    add(1, 0, 1, 0, 32'h2, 0, ERROR, 32'h44444444, "l0_err");
    add(1, 0, 1, 0, 32'h4, 0, ACCESS, 32'h22222222, "l0_err_to_rd");
    add(1, 0, 0, 0, 0, 0, FREE, 32'h22222222, "l0_idle");
    // DUT2, LAT=3: key change after one BUSY cycle restarts the latency
    add_req(2, 0, 1, 32'h24, 32'h99990009, 3, 0, 0, "wr24");
    add(2, 0, 1, 0, 32'h20, 0, BUSY, 0, "kc_rd20");
    add(2, 0, 1, 0, 32'h24, 0, BUSY, 0, "kc_restart");
    add_req(2, 1, 0, 32'h24, 0, 2, 0, 32'h99990009, "kc_rd24");
    // DUT3, LAT=4: abort by dropping, then abort by reset
    add_req(3, 0, 1, 32'h8, 32'hAAAA0008, 4, 0, 0, "wr8");
    add(3, 0, 0, 1, 32'h8, 32'h55, BUSY, 0, "abort_w");
    add(3, 0, 0, 1, 32'h8, 32'h55, BUSY, 0, "abort_w");
    add(3, 0, 0, 0, 0, 0, FREE, 0, "abort_drop");
    add_req(3, 1, 0, 32'h8, 0, 4, 0, 32'hAAAA0008, "rd8_old");
    add(3, 0, 0, 1, 32'h8, 32'h55, BUSY, 32'hAAAA0008, "rst_w");
    add(3, 0, 0, 1, 32'h8, 32'h55, BUSY, 32'hAAAA0008, "rst_w");
    add(3, 1, 0, 1, 32'h8, 32'h55, FREE, 0, "rst_mid_busy");
    add(3, 0, 0, 0, 0, 0, FREE, 0, "rst_after");
    add_req(3, 1, 0, 32'h8, 0, 4, 0, 0, "rd8_cleared");

    // ---------------- reset with random inputs ----------------
    for (int k = 0; k < NDUT; k++) rst_v[k] = 1'b1;
    repeat (2) begin
      for (int k = 0; k < NDUT; k++) begin
        ren_v[k]   = 1'($urandom_range(0, 1));
        wen_v[k]   = 1'($urandom_range(0, 1));
        addr_v[k]  = word_t'($urandom_range(0, 255)) << 2;
        store_v[k] = $urandom;
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst_state%0d", k), 32'(st_v[k]), 32'(FREE));
      check($sformatf("rst_load%0d", k), load_v[k], 32'h0);
      $display("reset dut%0d state=%0d load=%h", k, st_v[k], load_v[k]);
    end
    idle_all();

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      idle_all();
      rst_v[v.d]   = v.rst;
      ren_v[v.d]   = v.ren;
      wen_v[v.d]   = v.wen;
      addr_v[v.d]  = v.addr;
      store_v[v.d] = v.store;
      sb.push_back('{d: v.d, st: v.st, ld: v.ld, row: i});
      @(posedge clk); #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d].state", names[e.row], e.row), 32'(st_v[e.d]), 32'(e.st));
      check($sformatf("%s[%0d].load", names[e.row], e.row), load_v[e.d], e.ld);
      $display("row %0d dut%0d %s state=%0d load=%h", e.row, e.d, names[e.row],
               st_v[e.d], load_v[e.d]);
    end

    // ---------------- bounded wait for ACCESS, LAT=2 ----------------
    idle_all();
    ren_v[0]  = 1'b1;
    addr_v[0] = 32'h10;
    cyc   = 0;
    found = 1'b0;
    while (cyc < 20 && !found) begin
      @(posedge clk); #1;
      cyc++;
      if (st_v[0] == ACCESS) found = 1'b1;
    end
    check("wait_latency", 32'(cyc), 32'd3);
    check("wait_load", load_v[0], 32'hDEADBEEF);
    $display("wait dut0 rd10 cycles=%0d load=%h", cyc, load_v[0]);
    ren_v[0] = 1'b0;
    @(posedge clk); #1;
    check("wait_drop", 32'(st_v[0]), 32'(FREE));
    $display("drop dut0 state=%0d", st_v[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
